// File: rtl/clk_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl_pkg
// Shared types and defaults for the PF_CLK_DIV phase-alignment sequencer:
//   - cdc_state_e : sequencer state encoding
//   - clog2/max1  : elaboration-time width helpers
//   - DEF_*       : default parameter values
// ---------------------------------------------------------------------------
package clk_div_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SRESET = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_SLIP   = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
    } cdc_state_e;

    localparam int DEF_DIVIDER       = 4;
    localparam int DEF_SRESET_CYCLES = 4;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_CHECK_CYCLES  = 8;
    localparam int DEF_LOSS_CYCLES   = 4;
    localparam int DEF_RETRY_LIMIT   = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Counters are never narrower than one bit.
    function automatic int max1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/cdc_down_timer.sv
// ---------------------------------------------------------------------------
// cdc_down_timer
// Loadable down-counter. Loading N makes o_done high during the N-th cycle
// after the load edge, so a state that loads on entry and leaves on o_done
// lasts exactly N cycles (N >= 1).
//   i_clk, i_rst_n  : clock, async active-low reset
//   i_load          : load i_load_val on the next rising edge
//   i_load_val      : cycle count to time
//   o_done          : last cycle of the timed interval
// ---------------------------------------------------------------------------
module cdc_down_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Count register: load, otherwise count down and park at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/clk_div_phase_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_phase_ctrl
// Phase-alignment sequencer for a PF_CLK_DIV divider: sync-resets the
// divider, then bit-slips it one phase at a time until FRAME_OK stays high,
// retrying with a fresh sync reset and finally reporting FAIL. Re-aligns on
// loss of lock. All outputs are registered decodes of the state (Moore),
// so every output lags the state register by one cycle.
//   CLK, RESET_N  : system clock, async active-low reset
//   START         : (re)alignment request, honoured in IDLE/LOCKED/FAIL
//   FRAME_OK      : frame-alignment indicator (already in CLK domain)
//   DIV_SRESET    : divider sync reset pulse
//   DIV_BIT_SLIP  : one-cycle divider bit-slip pulse
//   BUSY/LOCKED/FAIL/LOCK_LOST : status
//   SLIP_COUNT    : slips applied since the last sync reset
// ---------------------------------------------------------------------------
module clk_div_phase_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIVIDER       = DEF_DIVIDER,
    parameter int SRESET_CYCLES = DEF_SRESET_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CHECK_CYCLES  = DEF_CHECK_CYCLES,
    parameter int LOSS_CYCLES   = DEF_LOSS_CYCLES,
    parameter int RETRY_LIMIT   = DEF_RETRY_LIMIT,
    localparam int SW           = max1(clog2(DIVIDER))
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          START,
    input  logic          FRAME_OK,
    output logic          DIV_SRESET,
    output logic          DIV_BIT_SLIP,
    output logic          BUSY,
    output logic          LOCKED,
    output logic          FAIL,
    output logic          LOCK_LOST,
    output logic [SW-1:0] SLIP_COUNT
);

    localparam int CW = max1(clog2(CHECK_CYCLES));
    localparam int LW = max1(clog2(LOSS_CYCLES));
    localparam int AW = max1(clog2(RETRY_LIMIT + 1));
    localparam int TMAX = (SRESET_CYCLES > SETTLE_CYCLES) ? SRESET_CYCLES : SETTLE_CYCLES;
    localparam int TW = max1(clog2(TMAX + 1));

    localparam logic [SW-1:0] SLIP_MAX  = SW'(DIVIDER - 1);
    localparam logic [CW-1:0] CHK_LAST  = CW'(CHECK_CYCLES - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_CYCLES - 1);
    localparam logic [AW-1:0] RETRY_MAX = AW'(RETRY_LIMIT);
    localparam logic [TW-1:0] SR_LOAD   = TW'(SRESET_CYCLES);
    localparam logic [TW-1:0] ST_LOAD   = TW'(SETTLE_CYCLES);

    cdc_state_e    r_state;
    cdc_state_e    w_next;
    logic [CW-1:0] r_chk_cnt;
    logic [LW-1:0] r_loss_cnt;
    logic [AW-1:0] r_attempts;
    logic [AW-1:0] w_att_inc;
    logic [SW-1:0] r_slip_cnt;
    logic          w_lock_lost;
    logic          w_enter;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_done;
    logic          r_div_sreset;
    logic          r_div_bit_slip;
    logic          r_busy;
    logic          r_locked;
    logic          r_fail;
    logic          r_lock_lost;

    // One timer serves both the sync-reset width and the settle wait.
    cdc_down_timer #(.W(TW)) u_timer (
        .i_clk      (CLK),
        .i_rst_n    (RESET_N),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus timer load on entry to SRESET/SETTLE.
    always_comb begin
        w_next      = r_state;
        w_lock_lost = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_att_inc   = r_attempts + AW'(1);
        case (r_state)
            ST_IDLE: begin
                if (START) w_next = ST_SRESET;
                else       w_next = ST_IDLE;
            end
            ST_SRESET: begin
                if (w_tmr_done) w_next = ST_SETTLE;
                else            w_next = ST_SRESET;
            end
            ST_SETTLE: begin
                if (w_tmr_done) w_next = ST_CHECK;
                else            w_next = ST_SETTLE;
            end
            ST_CHECK: begin
                if (FRAME_OK) begin
                    if (r_chk_cnt == CHK_LAST) w_next = ST_LOCKED;
                    else                       w_next = ST_CHECK;
                end else if (r_slip_cnt < SLIP_MAX) begin
                    w_next = ST_SLIP;
                end else if (w_att_inc < RETRY_MAX) begin
                    w_next = ST_SRESET;
                end else begin
                    w_next = ST_FAIL;
                end
            end
            ST_SLIP: begin
                w_next = ST_SETTLE;
            end
            ST_LOCKED: begin
                // An explicit START re-aligns without reporting a loss.
                if (START) begin
                    w_next = ST_SRESET;
                end else if (!FRAME_OK && (r_loss_cnt == LOSS_LAST)) begin
                    w_next      = ST_SRESET;
                    w_lock_lost = 1'b1;
                end else begin
                    w_next = ST_LOCKED;
                end
            end
            ST_FAIL: begin
                if (START) w_next = ST_FAIL == ST_FAIL ? ST_SRESET : ST_FAIL;
                else       w_next = ST_FAIL;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        w_enter = (w_next != r_state);
        if (w_enter && (w_next == ST_SRESET)) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = SR_LOAD;
        end else if (w_enter && (w_next == ST_SETTLE)) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = ST_LOAD;
        end else begin
            w_tmr_load = 1'b0;
            w_tmr_val  = '0;
        end
    end

    // Consecutive FRAME_OK=1 counter; any other situation restarts it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_chk_cnt <= '0;
        end else if ((r_state == ST_CHECK) && FRAME_OK && (r_chk_cnt != CHK_LAST)) begin
            r_chk_cnt <= r_chk_cnt + CW'(1);
        end else begin
            r_chk_cnt <= '0;
        end
    end

    // Consecutive FRAME_OK=0 counter while locked; a single 1 clears it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_loss_cnt <= '0;
        end else if ((r_state == ST_LOCKED) && !START && !FRAME_OK && !w_lock_lost) begin
            r_loss_cnt <= r_loss_cnt + LW'(1);
        end else begin
            r_loss_cnt <= '0;
        end
    end

    // Sync-reset attempt counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_attempts <= '0;
        end else if (((r_state == ST_IDLE) || (r_state == ST_FAIL)) && START) begin
            r_attempts <= '0;
        end else if (w_lock_lost) begin
            r_attempts <= '0;
        end else if ((r_state == ST_CHECK) && !FRAME_OK && (r_slip_cnt == SLIP_MAX)) begin
            r_attempts <= w_att_inc;
        end else begin
            r_attempts <= r_attempts;
        end
    end

    // Slip counter: cleared on entry to SRESET, saturates at DIVIDER-1.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_slip_cnt <= '0;
        end else if (w_enter && (w_next == ST_SRESET)) begin
            r_slip_cnt <= '0;
        end else if ((r_state == ST_SLIP) && (r_slip_cnt != SLIP_MAX)) begin
            r_slip_cnt <= r_slip_cnt + SW'(1);
        end else begin
            r_slip_cnt <= r_slip_cnt;
        end
    end

    // Registered output decode.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div_sreset   <= 1'b0;
            r_div_bit_slip <= 1'b0;
            r_busy         <= 1'b0;
            r_locked       <= 1'b0;
            r_fail         <= 1'b0;
            r_lock_lost    <= 1'b0;
        end else begin
            r_div_sreset   <= (r_state == ST_SRESET);
            r_div_bit_slip <= (r_state == ST_SLIP);
            r_busy         <= !((r_state == ST_IDLE) || (r_state == ST_LOCKED) ||
                                (r_state == ST_FAIL));
            r_locked       <= (r_state == ST_LOCKED);
            r_fail         <= (r_state == ST_FAIL);
            r_lock_lost    <= w_lock_lost;
        end
    end

    assign DIV_SRESET   = r_div_sreset;
    assign DIV_BIT_SLIP = r_div_bit_slip;
    assign BUSY         = r_busy;
    assign LOCKED       = r_locked;
    assign FAIL         = r_fail;
    assign LOCK_LOST    = r_lock_lost;
    assign SLIP_COUNT   = r_slip_cnt;

endmodule

// File: tb/tb_clk_div_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_phase_ctrl
// Directed bench for clk_div_phase_ctrl with default parameters. Inputs are
// driven and outputs sampled on the falling clock edge. FRAME_OK comes from a
// mode select: tied 0, tied 1, or a divider model that is aligned only after
// two slips since the last sync reset.
// ---------------------------------------------------------------------------
module tb_clk_div_phase_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       START;
    logic       FRAME_OK;
    logic       DIV_SRESET;
    logic       DIV_BIT_SLIP;
    logic       BUSY;
    logic       LOCKED;
    logic       FAIL;
    logic       LOCK_LOST;
    logic [1:0] SLIP_COUNT;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mode    = 1;     // 0: tied 0, 1: tied 1, 2: divider model
    int phase   = 0;     // model divider phase
    int sr_rise, sr_hi, sr_first;
    int slip_rise, slip_hi, slip_last, slip_min_gap;
    int ll_hi, overlap, excl;
    logic prev_sr   = 1'b0;
    logic prev_slip = 1'b0;
    int k, t0;

    clk_div_phase_ctrl dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .START        (START),
        .FRAME_OK     (FRAME_OK),
        .DIV_SRESET   (DIV_SRESET),
        .DIV_BIT_SLIP (DIV_BIT_SLIP),
        .BUSY         (BUSY),
        .LOCKED       (LOCKED),
        .FAIL         (FAIL),
        .LOCK_LOST    (LOCK_LOST),
        .SLIP_COUNT   (SLIP_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, DIV_SRESET, DIV_BIT_SLIP, BUSY, LOCKED, FAIL, LOCK_LOST, SLIP_COUNT};
    endfunction

    task automatic clr_mon();
        sr_rise = 0; sr_hi = 0; sr_first = -1;
        slip_rise = 0; slip_hi = 0; slip_last = 0; slip_min_gap = 1000000;
        ll_hi = 0;
    endtask

    // Drive FRAME_OK, advance one cycle, tally output pulses, update the model.
    task automatic step();
        if (mode == 1)      FRAME_OK = 1'b1;
        else if (mode == 2) FRAME_OK = (phase == 2);
        else                FRAME_OK = 1'b0;
        @(negedge CLK);
        cyc++;
        if (DIV_SRESET) begin
            sr_hi++;
            if (!prev_sr) begin sr_rise++; sr_first = cyc; end
        end
        if (DIV_BIT_SLIP) begin
            slip_hi++;
            if (!prev_slip) begin
                if (slip_rise > 0 && (cyc - slip_last) < slip_min_gap) slip_min_gap = cyc - slip_last;
                slip_rise++;
                slip_last = cyc;
            end
        end
        prev_sr   = DIV_SRESET;
        prev_slip = DIV_BIT_SLIP;
        if (LOCK_LOST) ll_hi++;
        if (DIV_SRESET && DIV_BIT_SLIP) overlap++;
        if (LOCKED && FAIL) excl++;
        if (DIV_SRESET)        phase = 0;
        else if (DIV_BIT_SLIP) phase = phase + 1;
    endtask

    // Step until LOCKED (sel 0) or FAIL (sel 1), bounded.
    task automatic wait_for(input int sel, input int limit, input string tag, output int n);
        n = 0;
        while (((sel == 0) ? LOCKED : FAIL) !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) check_val(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; START = 1'b0; FRAME_OK = 1'b1; overlap = 0; excl = 0;
        clr_mon();
        step(); step();
        check_val("reset_outs", outs(), 32'd0);
        RESET_N = 1'b1;
        step(); step();
        check_val("idle_outs", outs(), 32'd0);

        // 1: tied 1, lock with no slips; LOCKED 29 cycles after the START edge
        clr_mon(); mode = 1;
        START = 1'b1; step(); t0 = cyc; START = 1'b0;
        wait_for(0, 100, "t1_lock_timeout", k);
        check_val("t1_lock_latency", k, 32'd29);
        check_val("t1_sreset_start", sr_first - t0, 32'd1);
        check_val("t1_sreset_width", sr_hi, 32'd4);
        check_val("t1_no_slip", slip_hi, 32'd0);
        check_val("t1_slip_count", SLIP_COUNT, 32'd0);
        check_val("t1_busy", BUSY, 32'd0);

        // 2: model aligned after two slips
        clr_mon(); mode = 2;
        START = 1'b1; step(); START = 1'b0; step();
        wait_for(0, 300, "t2_lock_timeout", k);
        check_val("t2_slip_pulses", slip_rise, 32'd2);
        check_val("t2_slip_cycles", slip_hi, 32'd2);
        check_val("t2_slip_gap_ge17", (slip_min_gap >= 17) ? 32'd1 : 32'd0, 32'd1);
        check_val("t2_sreset_pulses", sr_rise, 32'd1);
        check_val("t2_locked", LOCKED, 32'd1);
        check_val("t2_slip_count", SLIP_COUNT, 32'd2);

        // 4: loss tolerance (3 zeros) then loss (4 zeros) and relock
        clr_mon(); mode = 0;
        repeat (3) step();
        mode = 2;
        for (int i = 0; i < 6; i++) begin
            step();
            check_val("t4_hold_locked", LOCKED, 32'd1);
        end
        check_val("t4_no_lock_lost", ll_hi, 32'd0);
        clr_mon(); mode = 0;
        repeat (3) step();
        check_val("t4_no_pulse_yet", LOCK_LOST, 32'd0);
        step();
        check_val("t4_lock_lost", LOCK_LOST, 32'd1);
        mode = 1;
        step();
        check_val("t4_lock_lost_1cyc", LOCK_LOST, 32'd0);
        check_val("t4_in_sreset", DIV_SRESET, 32'd1);
        wait_for(0, 100, "t4_relock_timeout", k);
        check_val("t4_lock_lost_count", ll_hi, 32'd1);
        check_val("t4_sreset_pulses", sr_rise, 32'd1);

        // 5: glitch on the 5th CHECK sample; START held high while busy
        clr_mon(); mode = 1;
        START = 1'b1; step();
        repeat (24) step();
        mode = 0; step(); mode = 1;
        check_val("t5_no_slip_yet", slip_hi, 32'd0);
        step();
        check_val("t5_slip_pulse", DIV_BIT_SLIP, 32'd1);
        START = 1'b0;
        step();
        wait_for(0, 100, "t5_lock_timeout", k);
        check_val("t5_start_ignored", sr_rise, 32'd1);
        check_val("t5_slip_count", SLIP_COUNT, 32'd1);

        // 3: tied 0 -> two attempts, six slips, FAIL; START restarts
        clr_mon(); mode = 0;
        START = 1'b1; step(); START = 1'b0;
        wait_for(1, 400, "t3_fail_timeout", k);
        check_val("t3_sreset_pulses", sr_rise, 32'd2);
        check_val("t3_slip_pulses", slip_rise, 32'd6);
        check_val("t3_slip_cycles", slip_hi, 32'd6);
        check_val("t3_outs", {BUSY, LOCKED, FAIL}, 32'd1);
        repeat (5) step();
        check_val("t3_fail_sticky", FAIL, 32'd1);
        START = 1'b1; step(); START = 1'b0; step();
        check_val("t3_restart", {DIV_SRESET, BUSY, FAIL}, 32'd6);

        // 6a: reset during an active DIV_SRESET
        RESET_N = 1'b0; #1;
        check_val("t6_rst_in_sreset", outs(), 32'd0);
        step(); RESET_N = 1'b1;
        repeat (5) step();
        check_val("t6_idle_after_rst", outs(), 32'd0);

        // 6b: reset during SETTLE
        START = 1'b1; step(); START = 1'b0;
        repeat (9) step();
        check_val("t6_busy_settle", {BUSY, DIV_SRESET}, 32'd2);
        RESET_N = 1'b0; #1;
        check_val("t6_rst_in_settle", outs(), 32'd0);
        step(); RESET_N = 1'b1;
        repeat (5) step();
        check_val("t6_idle_wait", outs(), 32'd0);
        START = 1'b1; step(); START = 1'b0; step();
        check_val("t6_restart_sreset", DIV_SRESET, 32'd1);

        check_val("never_sreset_and_slip", overlap, 32'd0);
        check_val("never_locked_and_fail", excl, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_phase_ctrl.md
Name: clk_div_phase_ctrl

Overview:
Sequencer for a PolarFire clock-divider core (PF_CLK_DIV) built with sync-reset and bit-slip enabled. It phase-aligns the divided clock to the digitizer frame. It issues a divider sync reset, then bit-slips the divider one position at a time until a downstream frame-alignment indicator is stable. It reports lock or fail and re-aligns on loss of lock. It sits beside the divider instance in the ADC clocking fabric, on the system clock domain.

Parameters:
DIVIDER, 4, division ratio of the controlled divider; also the number of distinct slip phases.
SRESET_CYCLES, 4, width of the DIV_SRESET pulse in CLK cycles (min 1).
SETTLE_CYCLES, 16, wait after each sync reset or slip before sampling FRAME_OK (min 1).
CHECK_CYCLES, 8, number of consecutive FRAME_OK=1 samples required to declare lock.
LOSS_CYCLES, 4, number of consecutive FRAME_OK=0 samples while locked that declares loss of lock.
RETRY_LIMIT, 2, number of full sync-reset attempts before FAIL (min 1).

Ports:
CLK  in  1  system clock; all logic is rising-edge.
RESET_N  in  1  asynchronous active-low reset.
START  in  1  request (re)alignment; level sampled, acted on only in IDLE, LOCKED or FAIL.
FRAME_OK  in  1  alignment indicator, already synchronised to CLK.
DIV_SRESET  out  1  active-high sync reset to the divider.
DIV_BIT_SLIP  out  1  single-cycle bit-slip pulse to the divider.
BUSY  out  1  high in every state except IDLE, LOCKED and FAIL.
LOCKED  out  1  alignment achieved and held.
FAIL  out  1  retries exhausted; sticky until the next START.
LOCK_LOST  out  1  one-cycle pulse when lock is lost.
SLIP_COUNT  out  clog2(DIVIDER)  slips applied since the last sync reset.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE. All outputs 0; all counters 0.
- States: IDLE, SRESET, SETTLE, CHECK, SLIP, LOCKED, FAIL. All outputs are registered (Moore).
- IDLE / LOCKED / FAIL + START=1 -> SRESET on the next edge. START in any other state is ignored. From IDLE/FAIL the attempt counter clears to 0.
- SRESET: DIV_SRESET=1 for exactly SRESET_CYCLES cycles. SLIP_COUNT is cleared on entry. Then -> SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles with a down-counter, then -> CHECK.
- CHECK: count consecutive FRAME_OK=1 cycles.
  - Reaching CHECK_CYCLES -> LOCKED.
  - Any FRAME_OK=0 -> if SLIP_COUNT < DIVIDER-1: -> SLIP.
  - Otherwise increment attempts; if attempts < RETRY_LIMIT -> SRESET, else -> FAIL.
- SLIP: DIV_BIT_SLIP=1 for exactly one cycle; SLIP_COUNT+1 (never wraps, max DIVIDER-1); -> SETTLE.
- LOCKED: LOCKED=1.
  - FRAME_OK=0 for LOSS_CYCLES consecutive cycles -> LOCK_LOST=1 for one cycle, attempts cleared, -> SRESET.
  - Fewer than LOSS_CYCLES zeros are tolerated; the loss counter clears on any FRAME_OK=1.
  - START while LOCKED -> SRESET, without a LOCK_LOST pulse.
- FAIL: FAIL=1 and BUSY=0 until START.
- DIV_SRESET and DIV_BIT_SLIP are never high in the same cycle.
- LOCKED and FAIL are mutually exclusive.
- Lock latency with no slips, measured from the START edge: 1 + SRESET_CYCLES + SETTLE_CYCLES + CHECK_CYCLES cycles.
- Each slip adds 1 + SETTLE_CYCLES + (cycles spent in CHECK before the failing sample).
- Reset asserted mid-sequence: all outputs drop to 0 immediately, including a DIV_SRESET or DIV_BIT_SLIP in progress.

Decomposition:
- Shared package clk_div_ctrl_pkg holds:
  - the state enum type;
  - a clog2 function;
  - default constants for DIVIDER, SETTLE_CYCLES, CHECK_CYCLES, LOSS_CYCLES and RETRY_LIMIT.
- One sub-module, cdc_down_timer: a loadable down-counter with a done flag. It is reused for the SRESET width and the SETTLE wait.
- The CHECK, LOSS, attempt and slip counters stay inline in the top-level module.

Test Plan:
All scenarios use the default parameters.
1. FRAME_OK tied 1, START pulse -> DIV_SRESET high for 4 cycles starting 1 cycle after START; LOCKED rises exactly 29 cycles after the START edge; no DIV_BIT_SLIP pulse; SLIP_COUNT=0.
2. Bench divider model with FRAME_OK=1 only after 2 slips -> exactly two 1-cycle DIV_BIT_SLIP pulses, each separated by at least 16 cycles of settle; LOCKED=1; SLIP_COUNT=2.
3. FRAME_OK tied 0 -> 2 attempts (DIV_SRESET pulsed twice), 3 slips per attempt (6 in total), then FAIL=1, BUSY=0, LOCKED=0. A following START clears FAIL and restarts at SRESET.
4. While LOCKED, FRAME_OK low for 3 cycles -> LOCKED remains 1 and there is no LOCK_LOST. FRAME_OK low for 4 cycles -> LOCK_LOST pulses once, the block enters SRESET, then relocks.
5. Single-cycle FRAME_OK=0 glitch in the 5th CHECK cycle -> treated as a failed check, so the block enters SLIP; START held high during BUSY has no effect.
6. RESET_N asserted during SETTLE and during an active DIV_SRESET -> all outputs 0 in the same cycle; after release the block is in IDLE and waits for START.
